// File: rtl/rr_grant_scheduler_if.sv
// Bundle of request/grant signals between the requesting masters and
// rr_grant_scheduler. The master modport is the requester side; the slave
// modport is the scheduler.
interface rr_grant_scheduler_if #(
    parameter int N  = 128,
    parameter int IW = $clog2(N)
) ();
    logic [N-1:0]  req;
    logic          done;
    logic [N-1:0]  grant;
    logic          any_grant;
    logic [IW-1:0] grant_idx;
    logic [N-1:0]  ptr;
    logic          timeout;

    modport master (
        output req, done,
        input  grant, any_grant, grant_idx, ptr, timeout
    );

    modport slave (
        input  req, done,
        output grant, any_grant, grant_idx, ptr, timeout
    );
endinterface

// File: rtl/rr_grant_scheduler.sv
// Round-robin grant scheduler: rotating one-hot priority pointer, wrap-around
// priority search, registered grant locked until the owner releases it.
// Optional feature macro: ARB_HOLD_TIMEOUT_EN -- when defined, a grant is
// forcibly released after MAX_HOLD cycles and `timeout` pulses for one cycle.
module rr_grant_scheduler #(
    parameter int N        = 128,
    parameter int MAX_HOLD = 16,
    parameter int IW       = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    rr_grant_scheduler_if.slave  bus
);

    if (N < 2 || MAX_HOLD < 1) begin : g_param_check
        $error("rr_grant_scheduler: need N >= 2 and MAX_HOLD >= 1");
    end

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  grant_q, grant_d;
    logic [IW-1:0] grant_idx_q, grant_idx_d;
    logic [N-1:0]  ptr_q, ptr_d;
    logic          timeout_q, timeout_d;

    logic [N-1:0]  req_hi;
    logic [N-1:0]  sel_src;
    logic [N-1:0]  sel_onehot;
    logic [IW-1:0] sel_idx;
    logic          normal_rel;
    logic          forced_rel;

`ifdef ARB_HOLD_TIMEOUT_EN
    localparam int CW = $clog2(MAX_HOLD + 1);
    logic [CW-1:0] hold_cnt_q, hold_cnt_d;
`endif

    // Wrap-around priority search: lowest request at or above the pointer,
    // otherwise the lowest request overall.
    always_comb begin
        req_hi     = bus.req & ~(ptr_q - N'(1));
        sel_src    = (|req_hi) ? req_hi : bus.req;
        sel_onehot = sel_src & (~sel_src + N'(1));
        sel_idx    = '0;
        for (int i = 0; i < N; i++) begin
            if (sel_onehot[i]) sel_idx = IW'(i);
        end
    end

    // Next-state logic: grant from IDLE, release from HOLD.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // can leave one unassigned and infer a latch.
        state_d     = state_q;
        grant_d     = grant_q;
        grant_idx_d = grant_idx_q;
        ptr_d       = ptr_q;
        timeout_d   = 1'b0;
        normal_rel  = 1'b0;
        forced_rel  = 1'b0;
`ifdef ARB_HOLD_TIMEOUT_EN
        hold_cnt_d  = hold_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    grant_d     = sel_onehot;
                    grant_idx_d = sel_idx;
                    state_d     = HOLD;
`ifdef ARB_HOLD_TIMEOUT_EN
                    hold_cnt_d  = '0;
`endif
                end
            end
            HOLD: begin
                normal_rel = bus.done || !bus.req[grant_idx_q];
`ifdef ARB_HOLD_TIMEOUT_EN
                forced_rel = (hold_cnt_q == CW'(MAX_HOLD - 1));
`endif
                if (normal_rel || forced_rel) begin
                    grant_d     = '0;
                    grant_idx_d = '0;
                    ptr_d       = {grant_q[N-2:0], grant_q[N-1]};
                    state_d     = IDLE;
                    timeout_d   = forced_rel && !normal_rel;
                end else begin
`ifdef ARB_HOLD_TIMEOUT_EN
                    hold_cnt_d = hold_cnt_q + CW'(1);
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with asynchronous reset to the idle, pointer-at-0 state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            grant_idx_q <= '0;
            ptr_q       <= N'(1);
            timeout_q   <= 1'b0;
`ifdef ARB_HOLD_TIMEOUT_EN
            hold_cnt_q  <= '0;
`endif
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values.
            state_q     <= state_d;
            grant_q     <= grant_d;
            grant_idx_q <= grant_idx_d;
            ptr_q       <= ptr_d;
            timeout_q   <= timeout_d;
`ifdef ARB_HOLD_TIMEOUT_EN
            hold_cnt_q  <= hold_cnt_d;
`endif
        end
    end

    assign bus.grant     = grant_q;
    assign bus.any_grant = (state_q == HOLD);
    assign bus.grant_idx = grant_idx_q;
    assign bus.ptr       = ptr_q;
`ifdef ARB_HOLD_TIMEOUT_EN
    assign bus.timeout   = timeout_q;
`else
    assign bus.timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// Self-checking bench for rr_grant_scheduler. Expected output snapshots are
// queued as stimulus is applied and compared once the DUT has responded.
module tb_rr_grant_scheduler;

    localparam int N  = 128;
    localparam int IW = $clog2(N);

    typedef struct {
        string         tag;
        logic [N-1:0]  grant;
        logic          any;
        logic [IW-1:0] idx;
        logic [N-1:0]  ptr;
        logic          to;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    exp_t sb_q[$];

    rr_grant_scheduler_if #(.N(N)) bus ();

    rr_grant_scheduler #(.N(N), .MAX_HOLD(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] oh(input int i);
        logic [N-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // gidx < 0 means idle (no grant expected)
    task automatic push_exp(input string tag, input int gidx, input int pidx, input logic to);
        exp_t e;
        e.tag   = tag;
        e.grant = (gidx < 0) ? '0 : oh(gidx);
        e.any   = (gidx >= 0);
        e.idx   = (gidx < 0) ? '0 : IW'(gidx);
        e.ptr   = oh(pidx);
        e.to    = to;
        sb_q.push_back(e);
    endtask

    task automatic compare_now();
        exp_t e;
        check("sb_depth", N'(sb_q.size()), N'(1));
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({e.tag, ".grant"},     bus.grant,          e.grant);
            check({e.tag, ".any_grant"}, N'(bus.any_grant),  N'(e.any));
            check({e.tag, ".grant_idx"}, N'(bus.grant_idx),  N'(e.idx));
            check({e.tag, ".ptr"},       bus.ptr,            e.ptr);
            check({e.tag, ".timeout"},   N'(bus.timeout),    N'(e.to));
        end
    endtask

    // Drive inputs, queue the expected post-edge state, clock once, compare.
    task automatic cycle(input logic [N-1:0] r, input logic d, input string tag,
                         input int gidx, input int pidx, input logic to);
        bus.req  = r;
        bus.done = d;
        push_exp(tag, gidx, pidx, to);
        @(posedge clk);
        #1;
        compare_now();
    endtask

    initial begin
        logic [N-1:0] r;
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        bus.req  = '0;
        bus.done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        push_exp("reset_init", -1, 0, 1'b0);
        compare_now();
        rst = 1'b0;

        // Pairwise requests 0 and 64
        r = oh(0) | oh(64);
        cycle(r, 1'b0, "pair_g0",     0,  0, 1'b0);
        cycle(r, 1'b1, "pair_b1",    -1,  1, 1'b0);
        cycle(r, 1'b0, "pair_g64",   64,  1, 1'b0);
        cycle(r, 1'b1, "pair_b65",   -1, 65, 1'b0);
        cycle(r, 1'b0, "pair_g0b",    0, 65, 1'b0);
        cycle(r, 1'b1, "pair_b1b",   -1,  1, 1'b0);

        // Wrap-around from bit 127 to bit 0
        cycle(oh(126), 1'b0, "wrap_g126", 126,   1, 1'b0);
        cycle(oh(126), 1'b1, "wrap_p127",  -1, 127, 1'b0);
        r = oh(5) | oh(127);
        cycle(r, 1'b0, "wrap_g127",  127, 127, 1'b0);
        cycle(r, 1'b1, "wrap_p0",     -1,   0, 1'b0);
        cycle(r, 1'b0, "wrap_g5",      5,   0, 1'b0);
        cycle(r, 1'b1, "wrap_p6",     -1,   6, 1'b0);

        // Owner withdraws its request; other requests ignored during HOLD
        cycle(oh(10),         1'b0, "wd_g10",    10,  6, 1'b0);
        cycle(oh(10) | oh(3), 1'b0, "wd_other",  10,  6, 1'b0);
        cycle(oh(3) & ~oh(3), 1'b0, "wd_rel",    -1, 11, 1'b0);
        cycle('0,             1'b0, "wd_idle",   -1, 11, 1'b0);

        // Hold tenure / timeout with req[3] held and no done
        cycle(oh(3), 1'b0, "to_g3", 3, 11, 1'b0);
`ifdef ARB_HOLD_TIMEOUT_EN
        for (int i = 0; i < 15; i++) cycle(oh(3), 1'b0, "to_hold", 3, 11, 1'b0);
        cycle(oh(3), 1'b0, "to_pulse", -1, 4, 1'b1);
        cycle(oh(3), 1'b0, "to_regrant", 3, 4, 1'b0);
        cycle(oh(3), 1'b1, "to_done",   -1, 4, 1'b0);
`else
        for (int i = 0; i < 119; i++) cycle(oh(3), 1'b0, "to_hold", 3, 11, 1'b0);
        cycle(oh(3), 1'b1, "to_done", -1, 4, 1'b0);
`endif

        // Reset mid-HOLD, then immediate re-grant from the reset pointer
        cycle(oh(70), 1'b0, "rst_g70", 70, 4, 1'b0);
        push_exp("rst_async", -1, 0, 1'b0);
        rst = 1'b1;
        #1;
        compare_now();
        #1;
        rst = 1'b0;
        cycle(oh(70), 1'b0, "rst_regrant", 70,  0, 1'b0);
        cycle(oh(70), 1'b1, "rst_release", -1, 71, 1'b0);
        cycle('0,     1'b0, "final_idle",  -1, 71, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rr_grant_scheduler.md
# rr_grant_scheduler

Sequential round-robin scheduler for the 128-way one-hot priority arbiter.
- Holds a rotating one-hot priority pointer and performs the wrap-around priority search internally.
- Registers and locks the resulting grant until the owner releases it, then advances the pointer past the last winner.
- Sits between the requesting masters and the shared resource, replacing the static priority vector with fair, stateful sharing.

## Interface
- `N`, 128, number of requesters (≥2)
- `MAX_HOLD`, 16, maximum grant tenure in cycles when the timeout feature is compiled in (≥1)
- `IW`, `$clog2(N)`, width of `grant_idx`
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `req`  in  N  request vector, bit i = requester i
- `done`  in  1  owner releases the current grant (ignored in IDLE)
- `grant`  out  N  registered one-hot grant; all-zero when idle
- `any_grant`  out  1  high while `grant` is non-zero
- `grant_idx`  out  IW  binary index of the granted bit; 0 when idle
- `ptr`  out  N  current one-hot priority pointer
- `timeout`  out  1  one-cycle pulse after a forced release

## Operation
- **Reset values** (applied immediately on `rst`, independent of `clk`):
  - `grant` = 0, `any_grant` = 0, `grant_idx` = 0, `timeout` = 0
  - `ptr` = 1 (bit 0), state = IDLE, hold counter = 0
- **Priority search** (combinational): select the first set `req` bit at index ≥ index(`ptr`), scanning upward and wrapping from N-1 to 0. This matches the semantics of the one-hot priority arbiter.
- **IDLE state**:
  - If `req` is non-zero: load `grant` with the selected one-hot bit and `grant_idx` with its index, set `any_grant`, and go to HOLD.
  - Otherwise remain in IDLE with all outputs zero.
- **HOLD state**: `grant`, `grant_idx` and `ptr` stay frozen. A release occurs on the edge that samples either condition:
  - `done` = 1, or
  - `req[grant_idx]` = 0 (the owner has withdrawn its request).
- **On release**:
  - `grant` ← 0, `any_grant` ← 0, `grant_idx` ← 0
  - `ptr` ← `grant` rotated left by 1 (bit N-1 wraps to bit 0)
  - state ← IDLE
- Requests other than the owner's have no effect during HOLD.
- **Fairness**: every requester that holds `req` continuously is granted within N grants.

## Timing
- Request to grant latency is 1 cycle: `req` sampled in IDLE at edge k gives `grant` valid in cycle k+1.
- Release to grant-clear latency is 1 cycle.
- There is always exactly one IDLE bubble cycle between consecutive grants, so back-to-back owners see a minimum grant period of tenure + 1.
- `ptr` changes only on the release edge. The new `ptr` is therefore visible during the bubble cycle and is the value used by the next search.
- Asserting `rst` mid-HOLD drops the grant asynchronously and restores `ptr` = 1. No release or timeout pulse is produced.
- `done` asserted together with a new request in the same cycle: the release applies first, and the new grant follows after the bubble.

## Configuration
- `ARB_HOLD_TIMEOUT_EN` **defined**:
  - A hold counter is cleared on entry to HOLD and increments every cycle spent in HOLD.
  - If no normal release has occurred, the grant is forcibly released after `any_grant` has been high for exactly `MAX_HOLD` cycles. The release follows the normal rules, including the `ptr` advance.
  - `timeout` pulses high for the first IDLE cycle after a forced release.
  - If a normal release and the timeout fall on the same edge, it is treated as a normal release and `timeout` stays 0.
- `ARB_HOLD_TIMEOUT_EN` **undefined**:
  - No counter is built and tenure is unbounded.
  - The `timeout` port remains and is tied to 0.

## Test plan
1. **Reset.** Assert `rst` mid-simulation without a clock edge. Required: `grant` = 0, `any_grant` = 0, `grant_idx` = 0, `timeout` = 0, `ptr` = 128'h1 immediately.
2. **Pairwise requests.** From reset, drive `req` bits 0 and 64, pulse `done` one cycle after each grant. Required sequence:
   - grant bit 0 (`grant_idx` = 0)
   - bubble with `ptr` = bit 1
   - grant bit 64 (`grant_idx` = 64)
   - bubble with `ptr` = bit 65
   - grant bit 0 again
3. **Wrap-around.** Bring `ptr` to bit 127 by granting and releasing requester 126, then drive `req` = bit 5 | bit 127. Required: grant bit 127; after `done`, `ptr` = bit 0; next grant is bit 5.
4. **Request withdrawal.** With requester 10 granted, deassert `req[10]` while `done` stays 0. Required: `grant` clears on the next edge and `ptr` = bit 11.
5. **Timeout.** With `ARB_HOLD_TIMEOUT_EN` and `MAX_HOLD` = 16, hold `req[3]` with no `done`. Required:
   - `any_grant` is high for exactly 16 cycles, then `timeout` = 1 for one cycle with `ptr` = bit 4.
   - Without the macro, the grant holds for 100+ cycles and `timeout` never asserts.
6. **Reset mid-HOLD.** Pulse `rst` while requester 70 is granted, with `req[70]` still high. Required: outputs return to reset values asynchronously; after `rst` deasserts, requester 70 is re-granted 1 cycle later with `grant_idx` = 70.
